// File: rtl/rv32_mem_pkg.sv
// Shared line geometry and responder state encoding for the data cache miss path.
package rv32_mem_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned LINE_ADDR_LEN = 3;
    localparam int unsigned MEM_ADDR_LEN  = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RWAIT  = 3'd1,
        RBURST = 3'd2,
        WBURST = 3'd3,
        WWAIT  = 3'd4
    } mem_state_e;

endpackage

// File: rtl/main_mem_responder_if.sv
// Cache <-> memory responder request/burst bus.
interface main_mem_responder_if #(
    parameter int unsigned AW = rv32_mem_pkg::MEM_ADDR_LEN
) ();
    import rv32_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AW-1:0]     req_line_addr;
    logic [WORD_W-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [WORD_W-1:0] rdata;
    logic              rdata_valid;
    logic              rdata_last;
    logic              wr_done;

    // Cache side
    modport master (
        output req_valid, req_we, req_line_addr, wdata, wdata_valid,
        input  req_ready, wdata_ready, rdata, rdata_valid, rdata_last, wr_done
    );

    // Responder side
    modport slave (
        input  req_valid, req_we, req_line_addr, wdata, wdata_valid,
        output req_ready, wdata_ready, rdata, rdata_valid, rdata_last, wr_done
    );

endinterface

// File: rtl/main_mem_responder_mem_word_array.sv
// Backing word array: one sync write port, one registered burst read port, one async debug read port.
module mem_word_array #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is never reset; contents survive an aborted burst
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered burst read; cleared by reset so rdata is 0 out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o    = rdata_q;
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder serving line refills and dirty-line writebacks with a fixed latency.
module main_mem_responder #(
    parameter int unsigned LINE_ADDR_LEN = rv32_mem_pkg::LINE_ADDR_LEN,
    parameter int unsigned MEM_ADDR_LEN  = rv32_mem_pkg::MEM_ADDR_LEN,
    parameter int unsigned LATENCY       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    main_mem_responder_if.slave      bus,
    input  logic [31:0]              debug_addr,
    output logic [31:0]              debug_out_data
);
    import rv32_mem_pkg::*;

    localparam int unsigned ARR_AW = MEM_ADDR_LEN + LINE_ADDR_LEN;
    localparam int unsigned WORDS  = 2 ** LINE_ADDR_LEN;
    localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0]         LAT_LOAD  = LAT_W'(LATENCY - 1);
    localparam logic [LINE_ADDR_LEN-1:0] LAST_BEAT = LINE_ADDR_LEN'(WORDS - 1);
    localparam logic [LINE_ADDR_LEN-1:0] PENULT    = LINE_ADDR_LEN'(WORDS - 2);

    mem_state_e               state_q;
    logic [MEM_ADDR_LEN-1:0]  line_addr_q;
    logic [LINE_ADDR_LEN-1:0] beat_q;
    logic [LAT_W-1:0]         lat_cnt_q;
    logic                     rdata_valid_q;
    logic                     rdata_last_q;
    logic                     wdata_ready_q;
    logic                     wr_done_q;

    logic                     hs;
    logic                     wr_en;
    logic                     rd_en;
    logic [LINE_ADDR_LEN-1:0] rd_beat_d;
    logic                     unused_dbg;

    assign bus.req_ready = (state_q == IDLE) && rst;
    assign hs            = bus.req_valid && bus.req_ready;
    assign wr_en         = (state_q == WBURST) && bus.wdata_valid;
    assign unused_dbg    = ^{debug_addr[31:ARR_AW+2], debug_addr[1:0]};

    // Array read is issued one cycle ahead of the beat it shows: first beat while the wait finishes
    always_comb begin
        rd_en     = 1'b0;
        rd_beat_d = '0;
        if (state_q == IDLE && hs && !bus.req_we && LATENCY == 1) begin
            rd_en = 1'b1;
        end else if (state_q == RWAIT && lat_cnt_q == LAT_W'(1)) begin
            rd_en = 1'b1;
        end else if (state_q == RBURST && beat_q != LAST_BEAT) begin
            rd_en     = 1'b1;
            rd_beat_d = beat_q + 1'b1;
        end
    end

    // Request FSM with beat and latency counters; beat_q tracks the beat on the bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            line_addr_q   <= '0;
            beat_q        <= '0;
            lat_cnt_q     <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            wdata_ready_q <= 1'b0;
            wr_done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        line_addr_q <= bus.req_line_addr;
                        beat_q      <= '0;
                        lat_cnt_q   <= LAT_LOAD;
                        if (bus.req_we) begin
                            state_q       <= WBURST;
                            wdata_ready_q <= 1'b1;
                        end else if (LATENCY == 1) begin
                            state_q       <= RBURST;
                            rdata_valid_q <= 1'b1;
                        end else begin
                            state_q <= RWAIT;
                        end
                    end
                end
                RWAIT: begin
                    lat_cnt_q <= lat_cnt_q - 1'b1;
                    if (lat_cnt_q == LAT_W'(1)) begin
                        state_q       <= RBURST;
                        rdata_valid_q <= 1'b1;
                    end
                end
                RBURST: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q       <= IDLE;
                        beat_q        <= '0;
                        rdata_valid_q <= 1'b0;
                        rdata_last_q  <= 1'b0;
                    end else begin
                        beat_q       <= beat_q + 1'b1;
                        rdata_last_q <= (beat_q == PENULT);
                    end
                end
                WBURST: begin
                    if (bus.wdata_valid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            state_q       <= WWAIT;
                            wdata_ready_q <= 1'b0;
                            lat_cnt_q     <= LAT_LOAD;
                            wr_done_q     <= (LATENCY == 1);
                        end
                    end
                end
                WWAIT: begin
                    if (lat_cnt_q == '0) begin
                        state_q   <= IDLE;
                        wr_done_q <= 1'b0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                        wr_done_q <= (lat_cnt_q == LAT_W'(1));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_word_array #(
        .ADDR_W (ARR_AW),
        .DATA_W (WORD_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .we_i       (wr_en),
        .waddr_i    ({line_addr_q, beat_q}),
        .wdata_i    (bus.wdata),
        .re_i       (rd_en),
        .raddr_i    ({line_addr_q, rd_beat_d}),
        .rdata_o    (bus.rdata),
        .dbg_addr_i (debug_addr[ARR_AW+1:2]),
        .dbg_data_o (debug_out_data)
    );

    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata_last  = rdata_last_q;
    assign bus.wdata_ready = wdata_ready_q;
    assign bus.wr_done     = wr_done_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder against a word-level memory model.
module tb_main_mem_responder;

    localparam int LAT = 4;
    localparam int NW  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] debug_addr;
    logic [31:0] debug_out_data;

    main_mem_responder_if bus ();

    main_mem_responder #(
        .LINE_ADDR_LEN (3),
        .MEM_ADDR_LEN  (10),
        .LATENCY       (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .debug_addr     (debug_addr),
        .debug_out_data (debug_out_data)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] model [int];
    logic [31:0] wbuf [NW];
    logic [9:0]  lines_q [$];

    // Wait (bounded) for req_ready; optionally require it to be up already
    task automatic wait_ready(input bit expect_now);
        int w = 0;
        while (!bus.req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_total++;
        if (bus.req_ready !== 1'b1) $display("FAIL ready_timeout got=%b want=1", bus.req_ready);
        else n_pass++;
        if (expect_now) begin
            n_total++;
            if (w != 0) $display("FAIL b2b_gap got=%0d cycles want=0", w);
            else n_pass++;
        end
    endtask

    // Writeback of wbuf to a line, with an optional stall after one beat
    task automatic do_write(input logic [9:0] line, input int stall_at, input int stall_len,
                            input bit hold, input bit b2b);
        int lat;
        wait_ready(b2b);
        bus.req_valid     = 1'b1;
        bus.req_we        = 1'b1;
        bus.req_line_addr = line;
        @(negedge clk);
        bus.req_valid = hold;
        for (int i = 0; i < NW; i++) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = wbuf[i];
            debug_addr      = 32'({line, 3'(i), 2'b00});
            n_total++;
            if ({bus.wdata_ready, bus.req_ready} !== 2'b10)
                $display("FAIL wr_beat%0d_ready got=%b want=10", i, {bus.wdata_ready, bus.req_ready});
            else n_pass++;
            @(negedge clk);
            model[int'(line) * NW + i] = wbuf[i];
            n_total++;
            if (debug_out_data !== wbuf[i])
                $display("FAIL dbg_after_write%0d got=%h want=%h", i, debug_out_data, wbuf[i]);
            else n_pass++;
            if (i == stall_at && i != NW - 1) begin
                bus.wdata_valid = 1'b0;
                repeat (stall_len) begin
                    n_total++;
                    if (bus.wdata_ready !== 1'b1) $display("FAIL stall_ready got=%b want=1", bus.wdata_ready);
                    else n_pass++;
                    @(negedge clk);
                end
            end
        end
        bus.wdata_valid = 1'b0;
        n_total++;
        if (bus.wdata_ready !== 1'b0) $display("FAIL wready_after_burst got=%b want=0", bus.wdata_ready);
        else n_pass++;
        lat = 1;
        while (!bus.wr_done && lat < LAT + 10) begin
            @(negedge clk);
            lat++;
        end
        n_total++;
        if (bus.wr_done !== 1'b1 || lat != LAT || bus.req_ready !== 1'b0)
            $display("FAIL wr_done_latency got=%0d (done=%b rdy=%b) want=%0d", lat, bus.wr_done, bus.req_ready, LAT);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.wr_done, bus.req_ready} !== 2'b01)
            $display("FAIL after_wr_done got=%b want=01", {bus.wr_done, bus.req_ready});
        else n_pass++;
    endtask

    // Refill of a line, checked against the model; noise drives wdata_valid throughout
    task automatic do_read(input logic [9:0] line, input bit hold, input bit b2b, input bit noise);
        int k;
        logic [31:0] exp;
        wait_ready(b2b);
        bus.req_valid     = 1'b1;
        bus.req_we        = 1'b0;
        bus.req_line_addr = line;
        if (noise) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = $urandom;
        end
        @(negedge clk);
        bus.req_valid = hold;
        k = 1;
        n_total++;
        if (bus.req_ready !== 1'b0) $display("FAIL rd_accept got=%b want=0", bus.req_ready);
        else n_pass++;
        while (!bus.rdata_valid && k < LAT + 10) begin
            if (noise) bus.wdata = $urandom;
            @(negedge clk);
            k++;
        end
        n_total++;
        if (bus.rdata_valid !== 1'b1 || k != LAT)
            $display("FAIL rd_latency got=%0d want=%0d", k, LAT);
        else n_pass++;
        for (int i = 0; i < NW; i++) begin
            exp = model[int'(line) * NW + i];
            n_total++;
            if ({bus.rdata_valid, bus.rdata_last, bus.req_ready, bus.wdata_ready} !== {1'b1, (i == NW - 1), 2'b00})
                $display("FAIL rd_beat%0d_ctl got=%b want=%b", i,
                         {bus.rdata_valid, bus.rdata_last, bus.req_ready, bus.wdata_ready}, {1'b1, (i == NW - 1), 2'b00});
            else n_pass++;
            n_total++;
            if (bus.rdata !== exp) $display("FAIL rd_beat%0d_data got=%h want=%h", i, bus.rdata, exp);
            else n_pass++;
            if (noise) bus.wdata = $urandom;
            @(negedge clk);
        end
        bus.wdata_valid = 1'b0;
        n_total++;
        if ({bus.rdata_valid, bus.rdata_last, bus.req_ready} !== 3'b001)
            $display("FAIL rd_end got=%b want=001", {bus.rdata_valid, bus.rdata_last, bus.req_ready});
        else n_pass++;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_total++;
        if ({bus.req_ready, bus.rdata_valid, bus.rdata_last, bus.wdata_ready, bus.wr_done} !== 5'b0 || bus.rdata !== 32'h0)
            $display("FAIL reset_outputs got=%b rdata=%h want=0", {bus.req_ready, bus.rdata_valid,
                     bus.rdata_last, bus.wdata_ready, bus.wr_done}, bus.rdata);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready got=%b want=1", bus.req_ready);
        else n_pass++;
    endtask

    task automatic test_refill();
        for (int i = 0; i < NW; i++) wbuf[i] = 32'h28 + 32'(i);
        do_write(10'h005, -1, 0, 1'b0, 1'b0);
        do_read(10'h005, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_writeback_readback();
        for (int i = 0; i < NW; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_write(10'h3FF, 3, 2, 1'b0, 1'b0);
        do_read(10'h3FF, 1'b0, 1'b0, 1'b0);
        debug_addr = 32'h0000_FFFC;
        #1;
        n_total++;
        if (debug_out_data !== 32'hA7) $display("FAIL dbg_fffc got=%h want=000000a7", debug_out_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [9:0] l;
        for (int op = 0; op < 4; op++) begin
            l = 10'($urandom_range(32, 200));
            if (op % 2 == 0) begin
                for (int i = 0; i < NW; i++) wbuf[i] = $urandom;
                do_write(l, -1, 0, 1'b1, op != 0);
                lines_q.push_back(l);
            end else begin
                do_read(lines_q[$urandom_range(0, lines_q.size() - 1)], op != 3, 1'b1, 1'b0);
            end
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_ignored();
        logic [9:0]  l;
        logic [31:0] exp;
        l = lines_q[lines_q.size() - 1];
        for (int i = 0; i < NW; i++) wbuf[i] = $urandom;
        do_write(l, -1, 0, 1'b0, 1'b0);
        debug_addr = 32'({l, 3'd0, 2'b00});
        exp = model[int'(l) * NW];
        repeat (5) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = $urandom;
            @(negedge clk);
            n_total++;
            if ({bus.wdata_ready, bus.req_ready} !== 2'b01 || debug_out_data !== exp)
                $display("FAIL idle_wdata_ignored got=%b/%h want=01/%h", {bus.wdata_ready, bus.req_ready}, debug_out_data, exp);
            else n_pass++;
        end
        do_read(l, 1'b1, 1'b0, 1'b1);
        do_read(l, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_write();
        for (int i = 0; i < NW; i++) wbuf[i] = $urandom;
        do_write(10'h010, -1, 0, 1'b0, 1'b0);
        for (int i = 0; i < NW; i++) wbuf[i] = ~model[16 * NW + i];
        wait_ready(1'b0);
        bus.req_valid     = 1'b1;
        bus.req_we        = 1'b1;
        bus.req_line_addr = 10'h010;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = wbuf[i];
            @(negedge clk);
            model[16 * NW + i] = wbuf[i];
        end
        bus.wdata = wbuf[3];
        #1 rst = 1'b0;
        #1;
        n_total++;
        if ({bus.req_ready, bus.rdata_valid, bus.rdata_last, bus.wdata_ready, bus.wr_done} !== 5'b0)
            $display("FAIL midwrite_reset_outputs got=%b want=00000", {bus.req_ready, bus.rdata_valid,
                     bus.rdata_last, bus.wdata_ready, bus.wr_done});
        else n_pass++;
        bus.wdata_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.req_ready !== 1'b1) $display("FAIL midwrite_release_ready got=%b want=1", bus.req_ready);
        else n_pass++;
        do_read(10'h010, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_refill();
        int k;
        bit seen;
        logic [9:0] l;
        l = lines_q[0];
        wait_ready(1'b0);
        bus.req_valid     = 1'b1;
        bus.req_we        = 1'b0;
        bus.req_line_addr = l;
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 1;
        while (!bus.rdata_valid && k < LAT + 10) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        n_total++;
        if (bus.rdata_valid !== 1'b1 || bus.rdata !== model[int'(l) * NW + 4])
            $display("FAIL refill_beat4 got=%b/%h want=1/%h", bus.rdata_valid, bus.rdata, model[int'(l) * NW + 4]);
        else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_total++;
        if ({bus.rdata_valid, bus.rdata_last} !== 2'b00)
            $display("FAIL refill_reset_drop got=%b want=00", {bus.rdata_valid, bus.rdata_last});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rdata_valid || bus.rdata_last) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL refill_no_more_beats got=1 want=0");
        else n_pass++;
        do_read(l, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int op = 0; op < 8; op++) begin
            if (op < 2 || $urandom_range(0, 1) == 0) begin
                for (int i = 0; i < NW; i++) wbuf[i] = $urandom;
                lines_q.push_back(10'($urandom));
                do_write(lines_q[lines_q.size() - 1], $urandom_range(0, 7), $urandom_range(0, 4), 1'b0, 1'b0);
            end else begin
                do_read(lines_q[$urandom_range(0, lines_q.size() - 1)], 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_we        = 1'b0;
        bus.req_line_addr = '0;
        bus.wdata         = '0;
        bus.wdata_valid   = 1'b0;
        debug_addr        = '0;
        test_reset();
        test_refill();
        test_writeback_readback();
        test_back_to_back();
        test_ignored();
        test_reset_mid_write();
        test_reset_mid_refill();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
